// File: rtl/modred_stream_ctrl.sv
// Streaming wrapper around the Barrett reducer: operand issue with credit-based flow control,
// modulus configuration holding, and an output FIFO that absorbs every non-stallable result.
module modred_stream_ctrl #(
    parameter int DATA_LENGTH = 64,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cfg_we_i,
    input  logic [DATA_LENGTH-1:0] cfg_q_i,
    input  logic [DATA_LENGTH-1:0] cfg_q_bl_i,
    input  logic [DATA_LENGTH-1:0] cfg_mu_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [DATA_LENGTH-1:0] s_data_i,
    output logic                   start_o,
    output logic [DATA_LENGTH-1:0] x_o,
    output logic [DATA_LENGTH-1:0] q_o,
    output logic [DATA_LENGTH-1:0] q_bl_o,
    output logic [DATA_LENGTH-1:0] mu_o,
    input  logic                   res_valid_i,
    input  logic [DATA_LENGTH-1:0] res_data_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [DATA_LENGTH-1:0] m_data_o,
    output logic                   busy_o,
    output logic                   err_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic                   cfg_loaded_q, cfg_loaded_d;
    logic [DATA_LENGTH-1:0] q_q, q_d, q_bl_q, q_bl_d, mu_q, mu_d;
    logic                   start_q, start_d;
    logic [DATA_LENGTH-1:0] x_q, x_d;
    logic [CNT_W-1:0]       in_flight_q, in_flight_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                   err_q, err_d;
    logic [DATA_LENGTH-1:0] mem_q [FIFO_DEPTH];

    logic           busy, s_ready, issue, res_hit, full, push, pop, cfg_ok;
    logic [CNT_W:0] occ;

    always_comb begin
        busy    = (in_flight_q != '0) || (count_q != '0);
        // Every issued operand owns a slot: in-flight results plus queued results never exceed depth.
        occ     = {1'b0, in_flight_q} + {1'b0, count_q};
        s_ready = cfg_loaded_q && (occ < DEPTH_EXT);
        issue   = s_valid_i && s_ready;
        res_hit = res_valid_i && (in_flight_q != '0);
        full    = (count_q == DEPTH_CNT);
        push    = res_hit && !full;
        pop     = (count_q != '0) && m_ready_i;
        cfg_ok  = cfg_we_i && !busy;
    end

    always_comb begin
        cfg_loaded_d = cfg_loaded_q | cfg_ok;
        q_d          = cfg_ok ? cfg_q_i    : q_q;
        q_bl_d       = cfg_ok ? cfg_q_bl_i : q_bl_q;
        mu_d         = cfg_ok ? cfg_mu_i   : mu_q;
        start_d      = issue;
        x_d          = issue ? s_data_i : x_q;
        in_flight_d  = in_flight_q + CNT_W'(issue) - CNT_W'(res_hit);
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        err_d        = err_q
                     | (cfg_we_i && busy)
                     | (res_valid_i && (in_flight_q == '0))
                     | (res_hit && full);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_loaded_q <= 1'b0;
            q_q          <= '0;
            q_bl_q       <= '0;
            mu_q         <= '0;
            start_q      <= 1'b0;
            x_q          <= '0;
            in_flight_q  <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            cfg_loaded_q <= cfg_loaded_d;
            q_q          <= q_d;
            q_bl_q       <= q_bl_d;
            mu_q         <= mu_d;
            start_q      <= start_d;
            x_q          <= x_d;
            in_flight_q  <= in_flight_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_q        <= err_d;
        end
    end

    // Storage needs no reset: an empty count makes stale entries invisible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= res_data_i;
        end
    end

    assign s_ready_o = s_ready;
    assign start_o   = start_q;
    assign x_o       = x_q;
    assign q_o       = q_q;
    assign q_bl_o    = q_bl_q;
    assign mu_o      = mu_q;
    assign m_valid_o = (count_q != '0);
    assign m_data_o  = mem_q[rd_ptr_q];
    assign busy_o    = busy;
    assign err_o     = err_q;
endmodule
